// File: rtl/switch_sched_pkg.sv
// Shared types and helpers for the round-robin switch scheduler.
package switch_sched_pkg;

   // Scheduler phases: waiting for a request, path granted, dead gap.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } sched_state_e;

   // Pointer width; a 1-bit pointer is kept even for degenerate sizes.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Hold counter width, one bit wider than strictly needed so HOLD-1 always fits.
   function automatic int cnt_width(input int hold);
      return $clog2(hold) + 1;
   endfunction

   // Gap counter width, same sizing rule as the hold counter.
   function automatic int gcnt_width(input int gap);
      return $clog2(gap) + 1;
   endfunction

   // Index of the set bit of a one-hot vector (0 when the vector is zero).
   function automatic int unsigned onehot_to_idx(input logic [63:0] oh);
      int unsigned idx;
      idx = 32'd0;
      for (int i = 0; i < 64; i++) begin
         idx = oh[i] ? i : idx;
      end
      return idx;
   endfunction

endpackage

// File: rtl/switch_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
   import switch_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = ptr_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  oh,
   output logic [PW-1:0] idx,
   output logic          valid
);

   logic [PW-1:0] cand_s [N];
   logic [N-1:0]  oh_s;
   logic          found_s;

   // Search order: ptr, ptr+1, ... wrapping modulo N.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         cand_s[k] = PW'((int'(ptr) + k) % N);
      end
   end

   // Mark only the first requester met along the search order.
   always_comb begin
      oh_s    = '0;
      found_s = 1'b0;
      for (int k = 0; k < N; k++) begin
         oh_s[cand_s[k]] = !found_s && req[cand_s[k]];
         found_s         = found_s | req[cand_s[k]];
      end
   end

   assign oh    = oh_s;
   assign idx   = PW'(onehot_to_idx(64'(oh_s)));
   assign valid = |req;

endmodule

// File: rtl/switch_scheduler.sv
// Round-robin scheduler sharing one gated path between N requesters, with
// bounded hold under contention, a break-before-make gap and ON/OFF pulses.
module switch_scheduler
   import switch_sched_pkg::*;
#(
   parameter int N    = 4,
   parameter int DW   = 1,
   parameter int HOLD = 8,
   parameter int GAP  = 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [N-1:0]    REQ,
   input  logic [N*DW-1:0] D,
   output logic [DW-1:0]   Q,
   output logic [N-1:0]    GNT,
   output logic [N-1:0]    ON,
   output logic [N-1:0]    OFF,
   output logic            BUSY
);

   localparam int PW = ptr_width(N);
   localparam int CW = cnt_width(HOLD);
   localparam int GW = gcnt_width(GAP);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

   sched_state_e  state_r, state_s;
   logic [N-1:0]  gnt_r, gnt_s;
   logic [N-1:0]  on_r, on_s;
   logic [N-1:0]  off_r, off_s;
   logic          busy_r, busy_s;
   logic [PW-1:0] ptr_r, ptr_s;
   logic [PW-1:0] hold_idx_r, hold_idx_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [GW-1:0] gcnt_r, gcnt_s;

   logic [N-1:0]  pick_oh_s;
   logic [PW-1:0] pick_idx_s;
   logic          pick_valid_s;
   logic          holder_req_s;
   logic          competitor_s;
   logic          release_s;
   logic [DW-1:0] q_s;

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .req   (REQ),
      .ptr   (ptr_r),
      .oh    (pick_oh_s),
      .idx   (pick_idx_s),
      .valid (pick_valid_s)
   );

   // Release when the holder lets go, or when it has used its slot and someone waits.
   always_comb begin
      holder_req_s = |(REQ & gnt_r);
      competitor_s = |(REQ & ~gnt_r);
      release_s    = !holder_req_s || ((cnt_r == HOLD_LAST) && competitor_s);
   end

   // Next-state, counters and pulse generation.
   always_comb begin
      state_s    = state_r;
      gnt_s      = gnt_r;
      on_s       = '0;
      off_s      = '0;
      ptr_s      = ptr_r;
      hold_idx_s = hold_idx_r;
      cnt_s      = cnt_r;
      gcnt_s     = gcnt_r;
      case (state_r)
         S_IDLE: begin
            if (pick_valid_s) begin
               state_s    = S_GRANT;
               gnt_s      = pick_oh_s;
               on_s       = pick_oh_s;
               hold_idx_s = pick_idx_s;
               cnt_s      = '0;
            end else begin
               state_s = S_IDLE;
               gnt_s   = '0;
            end
         end
         S_GRANT: begin
            if (release_s) begin
               state_s = S_GAP;
               gnt_s   = '0;
               off_s   = gnt_r;
               ptr_s   = PW'((int'(hold_idx_r) + 1) % N);
               gcnt_s  = '0;
            end else begin
               cnt_s = (cnt_r == HOLD_LAST) ? cnt_r : cnt_r + CW'(1'b1);
            end
         end
         S_GAP: begin
            if (gcnt_r == GAP_LAST) begin
               state_s = S_IDLE;
            end else begin
               gcnt_s = gcnt_r + GW'(1'b1);
            end
         end
         default: begin
            state_s = S_IDLE;
            gnt_s   = '0;
         end
      endcase
      busy_s = (state_s != S_IDLE);
   end

   // State and output registers; reset wins over everything.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r    <= S_IDLE;
         gnt_r      <= '0;
         on_r       <= '0;
         off_r      <= '0;
         busy_r     <= 1'b0;
         ptr_r      <= '0;
         hold_idx_r <= '0;
         cnt_r      <= '0;
         gcnt_r     <= '0;
      end else begin
         state_r    <= state_s;
         gnt_r      <= gnt_s;
         on_r       <= on_s;
         off_r      <= off_s;
         busy_r     <= busy_s;
         ptr_r      <= ptr_s;
         hold_idx_r <= hold_idx_s;
         cnt_r      <= cnt_s;
         gcnt_r     <= gcnt_s;
      end
   end

   // Output mux: only the granted slice passes, zero when nobody holds the path.
   always_comb begin
      q_s = '0;
      for (int i = 0; i < N; i++) begin
         q_s = q_s | (D[i*DW +: DW] & {DW{gnt_r[i]}});
      end
   end

   assign Q    = q_s;
   assign GNT  = gnt_r;
   assign ON   = on_r;
   assign OFF  = off_r;
   assign BUSY = busy_r;

endmodule
